// File: rtl/instr_register_alu_if.sv
// Bus bundle for instr_register_alu.
//   master : stimulus side, drives write/read requests and clear.
//   slave  : the register block, returns registered read data and entry_count.
// Write side : load_en, wr_addr, opcode, operand_a, operand_b
// Control    : clear (synchronous valid-bit clear)
// Read side  : rd_en, rd_addr -> rd_valid, rd_entry_valid, rd_opcode,
//              rd_op_a, rd_op_b, rd_result, rd_div_err
// Status     : entry_count
interface instr_register_alu_if #(
  parameter int OP_WIDTH = 8,
  parameter int DEPTH    = 32
);
  localparam int AW = $clog2(DEPTH);

  logic                  load_en;
  logic [AW-1:0]         wr_addr;
  logic [2:0]            opcode;
  logic [OP_WIDTH-1:0]   operand_a;
  logic [OP_WIDTH-1:0]   operand_b;
  logic                  clear;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic                  rd_valid;
  logic                  rd_entry_valid;
  logic [2:0]            rd_opcode;
  logic [OP_WIDTH-1:0]   rd_op_a;
  logic [OP_WIDTH-1:0]   rd_op_b;
  logic [2*OP_WIDTH-1:0] rd_result;
  logic                  rd_div_err;
  logic [AW:0]           entry_count;

  modport master (
    output load_en, wr_addr, opcode, operand_a, operand_b, clear, rd_en, rd_addr,
    input  rd_valid, rd_entry_valid, rd_opcode, rd_op_a, rd_op_b, rd_result,
           rd_div_err, entry_count
  );

  modport slave (
    input  load_en, wr_addr, opcode, operand_a, operand_b, clear, rd_en, rd_addr,
    output rd_valid, rd_entry_valid, rd_opcode, rd_op_a, rd_op_b, rd_result,
           rd_div_err, entry_count
  );
endinterface

// File: rtl/instr_register_alu.sv
// Instruction register with in-block ALU.
// Holds DEPTH entries of {opcode, operand A, operand B, result, div_err}.
// A write is captured into a stage register on one edge; the result is
// computed from the stage during the following cycle and committed on the
// next edge. Reads are registered (one cycle) and see a same-edge commit.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : instr_register_alu_if.slave (write/read/clear/status signals)
module instr_register_alu #(
  parameter int OP_WIDTH = 8,
  parameter int DEPTH    = 32
) (
  input  logic               clk,
  input  logic               reset,
  instr_register_alu_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 2 * OP_WIDTH;

  typedef enum logic [2:0] {
    OP_ZERO, OP_PASSA, OP_PASSB, OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_MOD
  } op_e;

  typedef struct packed {
    logic [AW-1:0]       addr;
    logic [2:0]          op;
    logic [OP_WIDTH-1:0] a;
    logic [OP_WIDTH-1:0] b;
  } wr_req_t;

  typedef struct packed {
    logic [2:0]          op;
    logic [OP_WIDTH-1:0] a;
    logic [OP_WIDTH-1:0] b;
    logic [RW-1:0]       res;
    logic                err;
  } entry_t;

  wr_req_t        stg_q;
  logic           stg_vld;
  entry_t         mem [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_nxt;
  logic [AW:0]    count_q, count_nxt;
  entry_t         cmt, rd_ent;
  logic           rd_ev;
  logic           rd_valid_q, rd_ev_q;
  entry_t         rd_ent_q;

  // Stage valid is reset so a reset between capture and commit drops the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stg_vld <= 1'b0;
    else       stg_vld <= bus.load_en;
  end

  always_ff @(posedge clk) begin
    if (bus.load_en) stg_q <= '{bus.wr_addr, bus.opcode, bus.operand_a, bus.operand_b};
  end

  // ALU on sign-extended operands; 2*OP_WIDTH holds every exact result,
  // including most-negative * most-negative and most-negative / -1.
  logic signed [RW-1:0] ea, eb, res;
  logic                 err;
  always_comb begin
    ea  = {{OP_WIDTH{stg_q.a[OP_WIDTH-1]}}, stg_q.a};
    eb  = {{OP_WIDTH{stg_q.b[OP_WIDTH-1]}}, stg_q.b};
    res = '0;
    err = 1'b0;
    case (op_e'(stg_q.op))
      OP_ZERO:  res = '0;
      OP_PASSA: res = ea;
      OP_PASSB: res = eb;
      OP_ADD:   res = ea + eb;
      OP_SUB:   res = ea - eb;
      OP_MULT:  res = ea * eb;
      OP_DIV:   if (eb == '0) err = 1'b1; else res = ea / eb;
      OP_MOD:   if (eb == '0) err = 1'b1; else res = ea % eb;
    endcase
    cmt = '{stg_q.op, stg_q.a, stg_q.b, res, err};
  end

  // Post-edge valid view: clear wipes everything, a coincident commit survives.
  always_comb begin
    valid_nxt = bus.clear ? '0 : valid_q;
    if (stg_vld) valid_nxt[stg_q.addr] = 1'b1;
    count_nxt = count_q;
    if (bus.clear)                             count_nxt = {AW'(0), stg_vld};
    else if (stg_vld && !valid_q[stg_q.addr]) count_nxt = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_nxt;
      count_q <= count_nxt;
    end
  end

  // Payload is not reset; valid bits mask it.
  always_ff @(posedge clk) begin
    if (stg_vld) mem[stg_q.addr] <= cmt;
  end

  // Read sees the state after this edge: bypass the commit, honour clear.
  always_comb begin
    rd_ev  = valid_nxt[bus.rd_addr];
    rd_ent = (stg_vld && stg_q.addr == bus.rd_addr) ? cmt : mem[bus.rd_addr];
    if (!rd_ev) rd_ent = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_ev_q    <= 1'b0;
      rd_ent_q   <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_ev_q  <= rd_ev;
        rd_ent_q <= rd_ent;
      end
    end
  end

  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_entry_valid = rd_ev_q;
  assign bus.rd_opcode      = rd_ent_q.op;
  assign bus.rd_op_a        = rd_ent_q.a;
  assign bus.rd_op_b        = rd_ent_q.b;
  assign bus.rd_result      = rd_ent_q.res;
  assign bus.rd_div_err     = rd_ent_q.err;
  assign bus.entry_count    = count_q;
endmodule

// File: tb/tb_instr_register_alu.sv
module tb_instr_register_alu;
  localparam int W  = 8;
  localparam int D  = 32;
  localparam int AW = $clog2(D);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_register_alu_if #(.OP_WIDTH(W), .DEPTH(D)) bus ();
  instr_register_alu #(.OP_WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic         ev;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] res;
    logic         err;
    logic [AW:0]  cnt;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int rd_n  = 0;

  task automatic chk(input string nm, input longint got, input longint want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic expect_rd(input logic ev, input int op, input int a, input int b,
                           input int res, input logic err, input int cnt);
    exp_t e;
    e.ev = ev; e.op = 3'(op); e.a = W'(a); e.b = W'(b);
    e.res = (2*W)'(res); e.err = err; e.cnt = (AW+1)'(cnt);
    q.push_back(e);
  endtask

  task automatic step(input logic we, input int wa, input int op, input int a, input int b,
                      input logic re, input int ra, input logic clr);
    bus.load_en = we; bus.wr_addr = AW'(wa); bus.opcode = 3'(op);
    bus.operand_a = W'(a); bus.operand_b = W'(b);
    bus.rd_en = re; bus.rd_addr = AW'(ra); bus.clear = clr;
    @(posedge clk); #1;
    bus.load_en = 1'b0; bus.rd_en = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every rd_valid cycle pops one expectation.
  initial begin
    exp_t act, e;
    forever begin
      @(negedge clk);
      if (!reset && bus.rd_valid) begin
        act = '{bus.rd_entry_valid, bus.rd_opcode, bus.rd_op_a, bus.rd_op_b,
                bus.rd_result, bus.rd_div_err, bus.entry_count};
        tests++;
        rd_n++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL rd_unexpected#%0d: rd_valid with no read pending, got %h", rd_n, act);
        end else begin
          e = q.pop_front();
          if (act !== e)begin
            fails++;
            $display("FAIL rd#%0d: got ev=%0b op=%0d a=%0d b=%0d res=%0d err=%0b cnt=%0d, expected ev=%0b op=%0d a=%0d b=%0d res=%0d err=%0b cnt=%0d",
                     rd_n, act.ev, act.op, $signed(act.a), $signed(act.b), $signed(act.res), act.err, act.cnt,
                     e.ev, e.op, $signed(e.a), $signed(e.b), $signed(e.res), e.err, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests, %0d failed", tests, fails);
    $fatal(1);
  end

  // ALU vector table: addr, opcode, A, B, result, err
  int t_addr[9] = '{10, 11, 12, 13, 14, 15, 16, 17, 18};
  int t_op  [9] = '{5, 6, 7, 6, 6, 4, 7, 0, 1};
  int t_a   [9] = '{-128, -7, -7, 5, -128, -128, 7, 5, -3};
  int t_b   [9] = '{-128, 2, 2, 0, -1, 127, -2, 6, 4};
  int t_res [9] = '{16384, -3, -1, 0, 128, -255, 1, 0, -3};
  int t_err [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    reset = 1'b1;
    bus.load_en = 0; bus.wr_addr = '0; bus.opcode = '0; bus.operand_a = '0;
    bus.operand_b = '0; bus.clear = 0; bus.rd_en = 0; bus.rd_addr = '0;
    @(posedge clk); #1;
    chk("reset_rd_valid", bus.rd_valid, 0);
    chk("reset_rd_result", bus.rd_result, 0);
    chk("reset_entry_count", bus.entry_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Every address reads invalid with zero data after reset.
    for (int i = 0; i < D; i++) begin
      expect_rd(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, i, 0);
    end
    idle(1);
    chk("rd_valid_one_cycle", bus.rd_valid, 0);

    // ADD at addr 3: same-edge read sees old contents, next-edge read bypasses.
    expect_rd(0, 0, 0, 0, 0, 0, 0);
    step(1, 3, 3, -15, 7, 1, 3, 0);
    expect_rd(1, 3, -15, 7, -8, 0, 1);
    step(0, 0, 0, 0, 0, 1, 3, 0);
    idle(3);
    expect_rd(1, 3, -15, 7, -8, 0, 1);
    step(0, 0, 0, 0, 0, 1, 3, 0);
    idle(2);
    chk("rd_valid_low_idle", bus.rd_valid, 0);
    chk("rd_result_hold", $signed(bus.rd_result), -8);
    chk("rd_op_a_hold", $signed(bus.rd_op_a), -15);

    // ALU vectors, each read via bypass on the commit edge.
    for (int i = 0; i < 9; i++) begin
      step(1, t_addr[i], t_op[i], t_a[i], t_b[i], 0, 0, 0);
      expect_rd(1, t_op[i], t_a[i], t_b[i], t_res[i], t_err[i] != 0, 2 + i);
      step(0, 0, 0, 0, 0, 1, t_addr[i], 0);
    end

    // Fill every address, then overwrite addr 0.
    for (int i = 0; i < D; i++) step(1, i, 3, i, 1, 0, 0, 0);
    step(1, 0, 2, 0, 9, 0, 0, 0);
    chk("count_full", bus.entry_count, D);
    expect_rd(1, 2, 0, 9, 9, 0, D);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    expect_rd(1, 3, 31, 1, 32, 0, D);
    step(0, 0, 0, 0, 0, 1, 31, 0);
    chk("count_saturated", bus.entry_count, D);

    // Clear coincident with commit to addr 5.
    step(1, 5, 1, 5, 2, 0, 0, 0);
    expect_rd(1, 1, 5, 2, 5, 0, 1);
    step(0, 0, 0, 0, 0, 1, 5, 1);
    expect_rd(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 4, 0);
    chk("count_after_clear", bus.entry_count, 1);

    // Reset between capture and commit of a write to addr 7.
    expect_rd(1, 1, 5, 2, 5, 0, 1);
    step(1, 7, 3, 1, 1, 1, 5, 0);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("async_rd_valid", bus.rd_valid, 0);
    chk("async_rd_result", bus.rd_result, 0);
    chk("async_rd_op_b", bus.rd_op_b, 0);
    chk("async_rd_entry_valid", bus.rd_entry_valid, 0);
    chk("async_entry_count", bus.entry_count, 0);
    #1;
    reset = 1'b0;
    expect_rd(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 7, 0);
    expect_rd(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 5, 0);
    idle(3);
    chk("count_after_reset", bus.entry_count, 0);
    chk("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
